// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: shares one write port between the WB stage and a long-latency unit.
// Optional post-reset zeroing of x1..x(DEPTH-1) is enabled by defining RF_CLEAR_EN.
module rf_wport_arbiter #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_B    = 5,
    parameter int DEPTH      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_we,
    input  logic [DEPTH_B-1:0] wb_wa,
    input  logic [WIDTH-1:0]   wb_wd,
    input  logic               lu_valid,
    input  logic [DEPTH_B-1:0] lu_wa,
    input  logic [WIDTH-1:0]   lu_wd,
    output logic               lu_ready,
    output logic               rf_we,
    output logic [DEPTH_B-1:0] rf_wa,
    output logic [WIDTH-1:0]   rf_wd,
    output logic               pipe_stall,
    output logic               init_busy
);

    localparam int                 CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]   STARVE_CNT = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               force_lu;
    logic               grant_lu;
    logic               grant_wb;

`ifdef RF_CLEAR_EN
    localparam logic [DEPTH_B-1:0] LAST_ADDR = DEPTH_B'(DEPTH - 1);
    logic [DEPTH_B-1:0] clr_addr_q, clr_addr_d;
`endif

    // Zero-latency grant: the register-file write bypass sees the winner in the same cycle.
    always_comb begin
        force_lu = lu_valid && (wait_cnt_q >= STARVE_CNT);
        grant_lu = (state_q == ST_RUN) && lu_valid && (!wb_we || force_lu);
        grant_wb = (state_q == ST_RUN) && wb_we && !grant_lu;
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
`ifdef RF_CLEAR_EN
        clr_addr_d = clr_addr_q;
`endif
        case (state_q)
            ST_START: begin
`ifdef RF_CLEAR_EN
                state_d    = ST_CLEAR;
                clr_addr_d = DEPTH_B'(1);
`else
                state_d    = ST_RUN;
`endif
            end
`ifdef RF_CLEAR_EN
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                if (!lu_valid || grant_lu) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q < STARVE_CNT) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    // Outputs decode from state_q only, so an asserted rst forces START values immediately.
    always_comb begin
        rf_we      = 1'b0;
        rf_wa      = '0;
        rf_wd      = '0;
        lu_ready   = 1'b0;
        pipe_stall = 1'b1;
        init_busy  = 1'b1;
        case (state_q)
`ifdef RF_CLEAR_EN
            ST_CLEAR: begin
                rf_we = 1'b1;
                rf_wa = clr_addr_q;
            end
`endif
            ST_RUN: begin
                init_busy  = 1'b0;
                pipe_stall = 1'b0;
                if (grant_lu) begin
                    rf_we      = 1'b1;
                    rf_wa      = lu_wa;
                    rf_wd      = lu_wd;
                    lu_ready   = 1'b1;
                    pipe_stall = wb_we;
                end else if (grant_wb) begin
                    rf_we = 1'b1;
                    rf_wa = wb_wa;
                    rf_wd = wb_wd;
                end
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_START;
            wait_cnt_q <= '0;
`ifdef RF_CLEAR_EN
            clr_addr_q <= DEPTH_B'(1);
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
`ifdef RF_CLEAR_EN
            clr_addr_q <= clr_addr_d;
`endif
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: vector table plus reset/startup sequences.
// Expected outputs are queued when inputs are driven and compared when outputs are sampled.
module tb_rf_wport_arbiter;

    localparam int WIDTH      = 32;
    localparam int DEPTH_B    = 5;
    localparam int DEPTH      = 32;
    localparam int STARVE_MAX = 4;
`ifdef RF_CLEAR_EN
    localparam int N_CLEAR = DEPTH - 1;
`else
    localparam int N_CLEAR = 0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               wb_we;
    logic [DEPTH_B-1:0] wb_wa;
    logic [WIDTH-1:0]   wb_wd;
    logic               lu_valid;
    logic [DEPTH_B-1:0] lu_wa;
    logic [WIDTH-1:0]   lu_wd;
    logic               lu_ready;
    logic               rf_we;
    logic [DEPTH_B-1:0] rf_wa;
    logic [WIDTH-1:0]   rf_wd;
    logic               pipe_stall;
    logic               init_busy;

    rf_wport_arbiter #(
        .WIDTH      (WIDTH),
        .DEPTH_B    (DEPTH_B),
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we      (wb_we),
        .wb_wa      (wb_wa),
        .wb_wd      (wb_wd),
        .lu_valid   (lu_valid),
        .lu_wa      (lu_wa),
        .lu_wd      (lu_wd),
        .lu_ready   (lu_ready),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .pipe_stall (pipe_stall),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               we;
        logic [DEPTH_B-1:0] wa;
        logic [WIDTH-1:0]   wd;
        logic               rdy;
        logic               stall;
        logic               busy;
    } exp_t;

    typedef struct {
        logic               wb_we;
        logic [DEPTH_B-1:0] wb_wa;
        logic [WIDTH-1:0]   wb_wd;
        logic               lu_valid;
        logic [DEPTH_B-1:0] lu_wa;
        logic [WIDTH-1:0]   lu_wd;
        exp_t               exp;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input string field,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, field, act, exp);
        end
    endtask

    task automatic drive(input logic we_i, input logic [DEPTH_B-1:0] wa_i, input logic [WIDTH-1:0] wd_i,
                         input logic lv_i, input logic [DEPTH_B-1:0] lwa_i, input logic [WIDTH-1:0] lwd_i);
        wb_we    = we_i;
        wb_wa    = wa_i;
        wb_wd    = wd_i;
        lu_valid = lv_i;
        lu_wa    = lwa_i;
        lu_wd    = lwd_i;
    endtask

    function automatic exp_t mk_exp(logic we, logic [DEPTH_B-1:0] wa, logic [WIDTH-1:0] wd,
                                    logic rdy, logic stall, logic busy);
        exp_t e;
        e.we = we; e.wa = wa; e.wd = wd; e.rdy = rdy; e.stall = stall; e.busy = busy;
        return e;
    endfunction

    task automatic expect_out(input exp_t e);
        sb_q.push_back(e);
    endtask

    task automatic sample(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            check(tag, "rf_we",      64'(rf_we),      64'(e.we));
            check(tag, "rf_wa",      64'(rf_wa),      64'(e.wa));
            check(tag, "rf_wd",      64'(rf_wd),      64'(e.wd));
            check(tag, "lu_ready",   64'(lu_ready),   64'(e.rdy));
            check(tag, "pipe_stall", 64'(pipe_stall), 64'(e.stall));
            check(tag, "init_busy",  64'(init_busy),  64'(e.busy));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive after the edge, queue the expectation, compare mid-cycle.
    task automatic cycle(input string tag, input exp_t e);
        expect_out(e);
        @(negedge clk);
        sample(tag);
    endtask

    // Called right after rst is released: START cycle, then n_clear zeroing writes.
    task automatic init_seq(input string tag, input int n_clear);
        cycle({tag, "_start"}, mk_exp(1'b0, '0, '0, 1'b0, 1'b1, 1'b1));
        for (int i = 1; i <= n_clear; i++) begin
            step();
            cycle($sformatf("%s_clr%0d", tag, i), mk_exp(1'b1, DEPTH_B'(i), '0, 1'b0, 1'b1, 1'b1));
        end
    endtask

    function automatic vec_t mk(logic we, logic [DEPTH_B-1:0] wa, logic [WIDTH-1:0] wd,
                                logic lv, logic [DEPTH_B-1:0] lwa, logic [WIDTH-1:0] lwd,
                                exp_t e);
        vec_t v;
        v.wb_we = we; v.wb_wa = wa; v.wb_wd = wd;
        v.lu_valid = lv; v.lu_wa = lwa; v.lu_wd = lwd;
        v.exp = e;
        return v;
    endfunction

    vec_t vecs[18];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Entries run back to back; the starvation counter carries across rows.
        vecs[0]  = mk(0, 0,  0,     0, 0,  0,      mk_exp(0, 0,  0,      0, 0, 0));
        vecs[1]  = mk(1, 5,  'h11,  0, 0,  0,      mk_exp(1, 5,  'h11,   0, 0, 0));
        vecs[2]  = mk(0, 0,  0,     1, 7,  'hABCD, mk_exp(1, 7,  'hABCD, 1, 0, 0));
        vecs[3]  = mk(0, 0,  0,     1, 0,  'hFF,   mk_exp(1, 0,  'hFF,   1, 0, 0));
        vecs[4]  = mk(1, 3,  'h30,  1, 9,  'h99,   mk_exp(1, 3,  'h30,   0, 0, 0));
        vecs[5]  = mk(1, 4,  'h40,  1, 9,  'h99,   mk_exp(1, 4,  'h40,   0, 0, 0));
        vecs[6]  = mk(1, 5,  'h50,  1, 9,  'h99,   mk_exp(1, 5,  'h50,   0, 0, 0));
        vecs[7]  = mk(1, 6,  'h60,  1, 9,  'h99,   mk_exp(1, 6,  'h60,   0, 0, 0));
        vecs[8]  = mk(1, 10, 'hA0,  1, 9,  'h99,   mk_exp(1, 9,  'h99,   1, 1, 0));
        vecs[9]  = mk(1, 10, 'hA0,  0, 0,  0,      mk_exp(1, 10, 'hA0,   0, 0, 0));
        vecs[10] = mk(1, 11, 'hB1,  1, 12, 'hC0,   mk_exp(1, 11, 'hB1,   0, 0, 0));
        vecs[11] = mk(1, 13, 'hD1,  1, 12, 'hC0,   mk_exp(1, 13, 'hD1,   0, 0, 0));
        vecs[12] = mk(1, 14, 'hE1,  1, 12, 'hC0,   mk_exp(1, 14, 'hE1,   0, 0, 0));
        vecs[13] = mk(1, 15, 'hF1,  1, 12, 'hC0,   mk_exp(1, 15, 'hF1,   0, 0, 0));
        vecs[14] = mk(1, 16, 'h161, 1, 12, 'hC0,   mk_exp(1, 12, 'hC0,   1, 1, 0));
        vecs[15] = mk(1, 16, 'h161, 1, 17, 'h177,  mk_exp(1, 16, 'h161,  0, 0, 0));
        vecs[16] = mk(0, 0,  0,     1, 17, 'h177,  mk_exp(1, 17, 'h177,  1, 0, 0));
        vecs[17] = mk(0, 0,  0,     0, 0,  0,      mk_exp(0, 0,  0,      0, 0, 0));

        // Requests present during reset and init must be ignored.
        rst = 1'b1;
        drive(1, 2, 'h22, 1, 8, 'h88);
        #2;
        cycle("reset", mk_exp(0, 0, 0, 0, 1, 1));
        step();
        cycle("reset_hold", mk_exp(0, 0, 0, 0, 1, 1));
        step();
        rst = 1'b0;
        init_seq("boot", N_CLEAR);

        step();
        cycle("first_run", mk_exp(1, 2, 'h22, 0, 0, 0));
        step();
        drive(0, 0, 0, 0, 0, 0);
        cycle("first_idle", mk_exp(0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 18; i++) begin
            step();
            drive(vecs[i].wb_we, vecs[i].wb_wa, vecs[i].wb_wd,
                  vecs[i].lu_valid, vecs[i].lu_wa, vecs[i].lu_wd);
            cycle($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset in the middle of an LU acceptance: outputs drop to START at once.
        step();
        drive(0, 0, 0, 1, 20, 'h5);
        cycle("hs_grant", mk_exp(1, 20, 'h5, 1, 0, 0));
        #1;
        rst = 1'b1;
        expect_out(mk_exp(0, 0, 0, 0, 1, 1));
        #1;
        sample("hs_reset");
        step();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
`ifdef RF_CLEAR_EN
        // Interrupt zeroing at x12, then confirm it restarts from x1.
        init_seq("mid", 12);
        #1;
        rst = 1'b1;
        expect_out(mk_exp(0, 0, 0, 0, 1, 1));
        #1;
        sample("clr_reset");
        step();
        rst = 1'b0;
        init_seq("restart", 2);
`else
        init_seq("rerun", 0);
        step();
        cycle("rerun_idle", mk_exp(0, 0, 0, 0, 0, 0));
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
